// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus target controller: FSM states, local register map, error bits.
// No logic of its own; no latency or backpressure.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        HOLD
    } state_t;

    localparam int WIN_MSB = 15;
    localparam int WIN_LSB = 12;
    localparam int HW_MSB  = 11;
    localparam int HW_LSB  = 1;

    localparam logic [10:0] REG_IRQ_PEND   = 11'd0;
    localparam logic [10:0] REG_IRQ_MASK   = 11'd1;
    localparam logic [10:0] REG_ERR_STATUS = 11'd2;
    localparam logic [10:0] REG_CTRL       = 11'd3;

    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_UNMAPPED = 1;

    function automatic logic is_target_win(input logic [3:0] win, input int num_targets);
        return (win != 4'd0) && (win <= 4'(num_targets));
    endfunction

endpackage

// File: rtl/io_irq_collector.sv
// Synchronises target interrupts, latches rising edges into PEND (W1C), masks them and drives io_irq.
// irq output lags a tgt_irq rise by 4 cycles; no backpressure, writes complete in one cycle.
module io_irq_collector #(
    parameter int NUM_TARGETS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_TARGETS-1:0] i_tgt_irq,
    input  logic                   i_pend_w1c,
    input  logic                   i_mask_wr,
    input  logic [NUM_TARGETS-1:0] i_wdata,
    input  logic [1:0]             i_be,
    input  logic                   i_err_irq,
    output logic [NUM_TARGETS-1:0] o_pend,
    output logic [NUM_TARGETS-1:0] o_mask,
    output logic                   o_irq
);
    logic [NUM_TARGETS-1:0] r_sync1, r_sync2, r_prev, r_pend, r_mask;
    logic                   r_irq;
    logic [NUM_TARGETS-1:0] w_bmask, w_rise, w_clr;

    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            w_bmask[i] = i_be[i/8];
        end
    end

    assign w_rise = r_sync2 & ~r_prev;
    assign w_clr  = i_pend_w1c ? (i_wdata & w_bmask) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_sync1 <= i_tgt_irq;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // A new edge in the same cycle as a clear keeps the bit set.
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            if (i_mask_wr) begin
                r_mask <= (r_mask & ~w_bmask) | (i_wdata & w_bmask);
            end
            r_irq   <= (|(r_pend & r_mask)) | i_err_irq;
        end
    end

    assign o_pend = r_pend;
    assign o_mask = r_mask;
    assign o_irq  = r_irq;

endmodule

// File: rtl/io_bus_target_ctrl.sv
// Decodes IO bridge transactions into local regs / target windows and returns a one-cycle ack.
// Local ack 2 cycles after bus_enable, target ack 2 cycles after ready; master holds until ack.
module io_bus_target_ctrl
    import io_bus_pkg::*;
#(
    parameter int          NUM_TARGETS    = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [15:0]               io_address,
    input  logic                      io_bus_enable,
    input  logic [1:0]                io_byte_enable,
    input  logic                      io_rw,
    input  logic [15:0]               io_write_data,
    output logic [15:0]               io_read_data,
    output logic                      io_acknowledge,
    output logic                      io_irq,
    output logic [NUM_TARGETS-1:0]    tgt_sel,
    output logic [10:0]               tgt_addr,
    output logic                      tgt_rd,
    output logic                      tgt_wr,
    output logic [1:0]                tgt_byteen,
    output logic [15:0]               tgt_wdata,
    input  logic [16*NUM_TARGETS-1:0] tgt_rdata,
    input  logic [NUM_TARGETS-1:0]    tgt_ready,
    input  logic [NUM_TARGETS-1:0]    tgt_irq
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 r_state, w_next;
    logic [15:1]            r_addr;
    logic                   r_rw, r_ack, r_ctrl;
    logic [1:0]             r_be, r_err_flags;
    logic [3:0]             r_err_win;
    logic [15:0]            r_wdata, r_rdata;
    logic [CNT_W-1:0]       r_cnt;

    logic [3:0]             w_win;
    logic [10:0]            w_off;
    logic                   w_local, w_target, w_tgt_ready, w_timeout, w_local_wr, w_unused;
    logic [NUM_TARGETS-1:0] w_sel, w_pend, w_mask;
    logic [15:0]            w_tgt_rdata, w_local_rdata;

    assign w_unused   = io_address[0];
    assign w_win      = r_addr[WIN_MSB:WIN_LSB];
    assign w_off      = r_addr[HW_MSB:HW_LSB];
    assign w_local    = (w_win == 4'd0);
    assign w_target   = is_target_win(w_win, NUM_TARGETS);
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_local_wr = (r_state == ACK) && w_local && !r_rw;

    always_comb begin
        w_sel       = '0;
        w_tgt_rdata = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            w_sel[i] = (w_win == 4'(i + 1));
            if (w_sel[i]) w_tgt_rdata = tgt_rdata[16*i +: 16];
        end
    end

    assign w_tgt_ready = |(tgt_ready & w_sel);

    always_comb begin
        w_local_rdata = '0;
        case (w_off)
            REG_IRQ_PEND:   w_local_rdata = 16'(w_pend);
            REG_IRQ_MASK:   w_local_rdata = 16'(w_mask);
            REG_ERR_STATUS: w_local_rdata = {r_err_win, 10'd0, r_err_flags};
            REG_CTRL:       w_local_rdata = {15'd0, r_ctrl};
            default:        w_local_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (io_bus_enable)
                         w_next = is_target_win(io_address[WIN_MSB:WIN_LSB], NUM_TARGETS) ? ACCESS : ACK;
            ACCESS:  if (w_tgt_ready || w_timeout) w_next = ACK;
            ACK:     w_next = HOLD;
            HOLD:    if (!io_bus_enable) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_ctrl      <= 1'b0;
            r_err_flags <= '0;
            r_err_win   <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: if (io_bus_enable) begin
                    r_addr  <= io_address[15:1];
                    r_rw    <= io_rw;
                    r_be    <= io_byte_enable;
                    r_wdata <= io_write_data;
                    r_cnt   <= '0;
                end
                ACCESS: begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    if (w_tgt_ready) begin
                        if (r_rw) r_rdata <= w_tgt_rdata;
                    end else if (w_timeout) begin
                        if (r_rw) r_rdata <= ERR_DATA;
                        r_err_flags[ERR_TIMEOUT] <= 1'b1;
                        r_err_win <= w_win;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    r_ack <= 1'b1;
                    if (w_local) begin
                        if (r_rw) begin
                            r_rdata <= w_local_rdata;
                        end else if (r_be[0]) begin
                            if (w_off == REG_ERR_STATUS) r_err_flags <= r_err_flags & ~r_wdata[1:0];
                            if (w_off == REG_CTRL)       r_ctrl <= r_wdata[0];
                        end
                    end else if (!w_target) begin
                        if (r_rw) r_rdata <= ERR_DATA;
                        r_err_flags[ERR_UNMAPPED] <= 1'b1;
                        r_err_win <= w_win;
                    end
                end
                default: ;
            endcase
        end
    end

    io_irq_collector #(.NUM_TARGETS(NUM_TARGETS)) u_irq (
        .i_clk      (clk_clk),
        .i_rst_n    (reset_reset_n),
        .i_tgt_irq  (tgt_irq),
        .i_pend_w1c (w_local_wr && (w_off == REG_IRQ_PEND)),
        .i_mask_wr  (w_local_wr && (w_off == REG_IRQ_MASK)),
        .i_wdata    (r_wdata[NUM_TARGETS-1:0]),
        .i_be       (r_be),
        .i_err_irq  (r_ctrl && (|r_err_flags)),
        .o_pend     (w_pend),
        .o_mask     (w_mask),
        .o_irq      (io_irq)
    );

    assign tgt_sel        = (r_state == ACCESS) ? w_sel : '0;
    assign tgt_rd         = (r_state == ACCESS) && r_rw;
    assign tgt_wr         = (r_state == ACCESS) && !r_rw;
    assign tgt_addr       = r_addr[HW_MSB:HW_LSB];
    assign tgt_byteen     = r_be;
    assign tgt_wdata      = r_wdata;
    assign io_read_data   = r_rdata;
    assign io_acknowledge = r_ack;

endmodule

// File: tb/tb_io_bus_target_ctrl.sv
// Directed bench for io_bus_target_ctrl: bus transfers against a simple responsive target model.
module tb_io_bus_target_ctrl;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [15:0] io_address, io_write_data, io_read_data;
    logic        io_bus_enable, io_rw, io_acknowledge, io_irq;
    logic [1:0]  io_byte_enable, tgt_byteen;
    logic [3:0]  tgt_sel, tgt_ready, tgt_irq;
    logic [10:0] tgt_addr;
    logic        tgt_rd, tgt_wr;
    logic [15:0] tgt_wdata;
    logic [63:0] tgt_rdata;

    int checks = 0;
    int errors = 0;

    int          ack_cyc, ack_cnt, rd_cnt, wr_cnt;
    logic [15:0] rdata, first_wdata;
    logic [3:0]  first_sel;
    logic [10:0] first_addr;

    io_bus_target_ctrl dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .io_address     (io_address),
        .io_bus_enable  (io_bus_enable),
        .io_byte_enable (io_byte_enable),
        .io_rw          (io_rw),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .io_acknowledge (io_acknowledge),
        .io_irq         (io_irq),
        .tgt_sel        (tgt_sel),
        .tgt_addr       (tgt_addr),
        .tgt_rd         (tgt_rd),
        .tgt_wr         (tgt_wr),
        .tgt_byteen     (tgt_byteen),
        .tgt_wdata      (tgt_wdata),
        .tgt_rdata      (tgt_rdata),
        .tgt_ready      (tgt_ready),
        .tgt_irq        (tgt_irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transfer; target rdy_tgt asserts ready on its rdy_at-th strobe cycle (0 = never),
    // spur is driven onto tgt_ready throughout, enable is held hold cycles past the ack.
    task automatic xfer(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                        input logic [15:0] wd, input int rdy_tgt, input int rdy_at,
                        input logic [3:0] spur, input int hold);
        ack_cyc = 0; ack_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        rdata = '0; first_sel = '0; first_addr = '0; first_wdata = '0;
        io_address = addr; io_rw = rw; io_byte_enable = be; io_write_data = wd;
        io_bus_enable = 1'b1;
        tgt_ready = spur;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            tick();
            if (io_acknowledge) begin
                ack_cnt++;
                if (ack_cyc == 0) begin
                    ack_cyc = cyc;
                    rdata = io_read_data;
                end
            end
            if (tgt_rd || tgt_wr) begin
                if (rd_cnt + wr_cnt == 0) begin
                    first_sel = tgt_sel; first_addr = tgt_addr; first_wdata = tgt_wdata;
                end
                rd_cnt += int'(tgt_rd);
                wr_cnt += int'(tgt_wr);
            end
            tgt_ready = spur;
            if ((tgt_rd || tgt_wr) && (rd_cnt + wr_cnt == rdy_at)) tgt_ready[rdy_tgt] = 1'b1;
            if (ack_cyc != 0 && cyc >= ack_cyc + hold) break;
        end
        io_bus_enable = 1'b0;
        tgt_ready = '0;
        tick();
    endtask

    initial begin
        reset_reset_n = 1'b0;
        io_address = '0; io_write_data = '0; io_bus_enable = 1'b0; io_rw = 1'b0;
        io_byte_enable = '0; tgt_ready = '0; tgt_irq = '0;
        tgt_rdata = {16'h0000, 16'h0000, 16'hBEEF, 16'h5555};
        tick(); tick();
        chk("rst_ack", io_acknowledge, 0);
        chk("rst_irq", io_irq, 0);
        chk("rst_rdata", io_read_data, 0);
        chk("rst_sel", tgt_sel, 0);
        chk("rst_strobes", {tgt_rd, tgt_wr}, 0);
        reset_reset_n = 1'b1;
        tick();

        // target0 write, ready on 3rd strobe cycle
        xfer(16'h1004, 1'b0, 2'b11, 16'h1234, 0, 3, 4'b0000, 0);
        chk("wr_strobes", wr_cnt, 3);
        chk("wr_rd_strobes", rd_cnt, 0);
        chk("wr_sel", first_sel, 4'b0001);
        chk("wr_addr", first_addr, 2);
        chk("wr_wdata", first_wdata, 16'h1234);
        chk("wr_ack_cyc", ack_cyc, 5);
        chk("wr_ack_cnt", ack_cnt, 1);

        // target1 read, ready immediately
        xfer(16'h2000, 1'b1, 2'b11, 16'h0000, 1, 1, 4'b0000, 0);
        chk("rd_data", rdata, 16'hBEEF);
        chk("rd_ack_cyc", ack_cyc, 3);
        chk("rd_sel", first_sel, 4'b0010);
        chk("rd_strobes", rd_cnt, 1);

        // target0 never ready, others raise ready which must be ignored
        xfer(16'h1000, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b1110, 0);
        chk("to_ack_cyc", ack_cyc, 257);
        chk("to_strobes", rd_cnt, 255);
        chk("to_data", rdata, 16'hDEAD);
        xfer(16'h0004, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("err_after_to", rdata, 16'h1001);
        chk("local_ack_cyc", ack_cyc, 2);
        chk("irq_ctrl_off", io_irq, 0);

        xfer(16'h0004, 1'b0, 2'b11, 16'h0001, 0, 0, 4'b0000, 0);
        xfer(16'h0004, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("err_w1c", rdata, 16'h1000);

        // unmapped window
        xfer(16'hF000, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("unm_ack_cyc", ack_cyc, 2);
        chk("unm_data", rdata, 16'hDEAD);
        chk("unm_strobes", rd_cnt + wr_cnt, 0);
        xfer(16'h0004, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("err_unm", rdata, 16'hF002);

        xfer(16'h0006, 1'b0, 2'b11, 16'h0001, 0, 0, 4'b0000, 0);
        chk("irq_err_en", io_irq, 1);
        xfer(16'h0006, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("ctrl_rd", rdata, 16'h0001);
        xfer(16'h0004, 1'b0, 2'b11, 16'h0003, 0, 0, 4'b0000, 0);
        tick();
        chk("irq_err_clr", io_irq, 0);
        xfer(16'h000A, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("unused_off", rdata, 16'h0000);

        // mask with byte lanes
        xfer(16'h0002, 1'b0, 2'b11, 16'h0004, 0, 0, 4'b0000, 0);
        xfer(16'h0002, 1'b0, 2'b10, 16'hFFFF, 0, 0, 4'b0000, 0);
        xfer(16'h0002, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("mask_be", rdata, 16'h0004);

        // interrupt edge, then clear colliding with a new edge
        tgt_irq = 4'b0100;
        repeat (4) tick();
        chk("irq_tgt", io_irq, 1);
        xfer(16'h0000, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("pend_set", rdata, 16'h0004);
        tgt_irq = 4'b0000;
        repeat (3) tick();
        tgt_irq = 4'b0100;
        tick();
        xfer(16'h0000, 1'b0, 2'b11, 16'h0004, 0, 0, 4'b0000, 0);
        xfer(16'h0000, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("pend_set_wins", rdata, 16'h0004);
        xfer(16'h0000, 1'b0, 2'b11, 16'h0004, 0, 0, 4'b0000, 0);
        xfer(16'h0000, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("pend_w1c", rdata, 16'h0000);
        tick();
        chk("irq_cleared", io_irq, 0);

        // master holds enable after ack
        xfer(16'h3010, 1'b0, 2'b11, 16'hA5A5, 2, 2, 4'b0000, 10);
        chk("hold_ack_cnt", ack_cnt, 1);
        chk("hold_strobes", wr_cnt, 2);
        chk("hold_sel", first_sel, 4'b0100);
        chk("hold_addr", first_addr, 8);
        chk("hold_ack_cyc", ack_cyc, 4);

        // reset during ACCESS
        tgt_irq = 4'b0000;
        io_address = 16'h1000; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
        tick(); tick();
        chk("pre_rst_rd", tgt_rd, 1);
        reset_reset_n = 1'b0;
        #1;
        chk("rst_mid_rd", tgt_rd, 0);
        chk("rst_mid_sel", tgt_sel, 0);
        chk("rst_mid_ack", io_acknowledge, 0);
        tick();
        io_bus_enable = 1'b0;
        reset_reset_n = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ack_cnt += int'(io_acknowledge);
        end
        chk("rst_no_ack", ack_cnt, 0);
        xfer(16'h0002, 1'b1, 2'b11, 16'h0000, 0, 0, 4'b0000, 0);
        chk("rst_mask", rdata, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
